// File: rtl/prog_freq_divider_if.sv
// prog_freq_divider_if: control and status bundle of the programmable divider.
// The master side drives enable, sync and ratio writes. The slave side (the
// divider) returns the active ratio, the phase, the tick and the taps.
interface prog_freq_divider_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NTAPS = 3
);
   logic             en;
   logic             sync;
   logic             ratio_wr;
   logic [WIDTH-1:0] ratio_in;
   logic [WIDTH-1:0] ratio_cur;
   logic             pending;
   logic [WIDTH-1:0] cnt;
   logic             tick;
   logic             clk_out;
   logic [NTAPS-1:0] taps;

   modport master (
      output en, sync, ratio_wr, ratio_in,
      input  ratio_cur, pending, cnt, tick, clk_out, taps
   );

   modport slave (
      input  en, sync, ratio_wr, ratio_in,
      output ratio_cur, pending, cnt, tick, clk_out, taps
   );
endinterface

// File: rtl/prog_freq_divider.sv
// prog_freq_divider: programmable divide-by-N clock-enable generator.
// It produces a one-cycle tick per period, a registered near-50% square wave
// and optional power-of-two taps. All logic runs in the clk domain.
// Optional macro FD_TAPS_EN builds the tap counter. When the macro is not
// defined, taps is tied to 0.
module prog_freq_divider #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned NTAPS       = 3,
   parameter int unsigned RESET_RATIO = 2
) (
   input  logic                clk,
   input  logic                rst,
   prog_freq_divider_if.slave  bus
);

   localparam logic [WIDTH-1:0] RST_RATIO = WIDTH'(RESET_RATIO);
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] ratio_cur_q, ratio_cur_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             clk_out_q, clk_out_d;
   logic [WIDTH-1:0] wr_ratio;
   logic             at_end;
   logic             tick_c;

   // A requested ratio of 0 is mapped to 1
   assign wr_ratio = (bus.ratio_in == '0) ? ONE : bus.ratio_in;
   assign at_end   = (cnt_q == (ratio_cur_q - ONE));
   // sync forces a zero tick so the realigned phase starts cleanly
   assign tick_c   = bus.en & ~bus.sync & at_end;

   // Next-state logic for phase, ratio, shadow and square wave
   always_comb begin
      cnt_d       = cnt_q;
      ratio_cur_d = ratio_cur_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      clk_out_d   = clk_out_q;

      if (bus.sync) begin
         cnt_d     = '0;
         clk_out_d = 1'b0;
         pending_d = 1'b0;
         if (bus.ratio_wr) begin
            ratio_cur_d = wr_ratio;
            shadow_d    = wr_ratio;
         end else if (pending_q) begin
            ratio_cur_d = shadow_q;
         end
      end else if (!bus.en) begin
         // While frozen, a new or pending ratio loads at once and restarts the phase
         if (bus.ratio_wr) begin
            ratio_cur_d = wr_ratio;
            shadow_d    = wr_ratio;
            pending_d   = 1'b0;
            cnt_d       = '0;
            clk_out_d   = 1'b0;
         end else if (pending_q) begin
            ratio_cur_d = shadow_q;
            pending_d   = 1'b0;
            cnt_d       = '0;
            clk_out_d   = 1'b0;
         end
      end else begin
         if (bus.ratio_wr) begin
            shadow_d  = wr_ratio;
            pending_d = 1'b1;
         end
         if (at_end) begin
            cnt_d = '0;
            // A write in the boundary cycle goes straight through
            if (bus.ratio_wr) begin
               ratio_cur_d = wr_ratio;
               pending_d   = 1'b0;
            end else if (pending_q) begin
               ratio_cur_d = shadow_q;
               pending_d   = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
         // High once cnt reaches N - ceil(N/2), which equals floor(N/2)
         clk_out_d = (cnt_d >= (ratio_cur_d >> 1));
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         ratio_cur_q <= RST_RATIO;
         shadow_q    <= RST_RATIO;
         pending_q   <= 1'b0;
         clk_out_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         ratio_cur_q <= ratio_cur_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         clk_out_q   <= clk_out_d;
      end
   end

`ifdef FD_TAPS_EN
   logic [NTAPS-1:0] tap_cnt_q, tap_cnt_d;

   // Binary tap counter advances on tick and is cleared by sync
   always_comb begin
      tap_cnt_d = tap_cnt_q;
      if (bus.sync) begin
         tap_cnt_d = '0;
      end else if (tick_c) begin
         tap_cnt_d = tap_cnt_q + NTAPS'(1);
      end
   end

   // Tap counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_cnt_q <= '0;
      end else begin
         tap_cnt_q <= tap_cnt_d;
      end
   end

   assign bus.taps = tap_cnt_q;
`else
   assign bus.taps = '0;
`endif

   assign bus.ratio_cur = ratio_cur_q;
   assign bus.pending   = pending_q;
   assign bus.cnt       = cnt_q;
   assign bus.tick      = tick_c;
   assign bus.clk_out   = clk_out_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// tb_prog_freq_divider: directed vector table, hand-written corner sequences and
// random traffic. Every cycle is also compared against a behavioural model.
module tb_prog_freq_divider;

   localparam int unsigned WIDTH       = 8;
   localparam int unsigned NTAPS       = 3;
   localparam int unsigned RESET_RATIO = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   prog_freq_divider_if #(.WIDTH(WIDTH), .NTAPS(NTAPS)) bus ();

   prog_freq_divider #(
      .WIDTH(WIDTH), .NTAPS(NTAPS), .RESET_RATIO(RESET_RATIO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       rst, en, sync, wr;
      logic [7:0] rin;
      bit         chk;
      logic [7:0] cnt, ratio;
      logic       pend, tick, clk_out;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // Behavioural model: state that is visible at the outputs
   int m_n, m_cnt, m_shadow, m_pend, m_clk, m_ticks;
   bit m_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int rs, input int e, input int s, input int w,
                               input int r, input int ck, input int c, input int n,
                               input int p, input int t, input int co);
      vec_t v;
      v.rst = rs[0]; v.en = e[0]; v.sync = s[0]; v.wr = w[0]; v.rin = 8'(r);
      v.chk = ck[0]; v.cnt = 8'(c); v.ratio = 8'(n); v.pend = p[0];
      v.tick = t[0]; v.clk_out = co[0];
      return v;
   endfunction

   // Rules from the divider description, applied one clock edge at a time
   task automatic model_step(input logic rs, input logic e, input logic s,
                             input logic w, input logic [7:0] r);
      int wv;
      bit tk;
      if (rs) begin
         m_n = int'(RESET_RATIO); m_shadow = int'(RESET_RATIO);
         m_pend = 0; m_cnt = 0; m_clk = 0; m_ticks = 0; m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      wv = (r == 8'd0) ? 1 : int'(r);
      tk = e && !s && (m_cnt == m_n - 1);
      if (w) begin m_shadow = wv; m_pend = 1; end
      if (s) begin
         if (m_pend != 0) m_n = m_shadow;
         m_pend = 0; m_cnt = 0; m_clk = 0; m_ticks = 0;
      end else if (!e) begin
         if (m_pend != 0) begin
            m_n = m_shadow; m_pend = 0; m_cnt = 0; m_clk = 0;
         end
      end else begin
         if (tk) begin
            m_ticks++;
            if (m_pend != 0) begin m_n = m_shadow; m_pend = 0; end
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
         m_clk = (m_cnt >= m_n - (m_n + 1) / 2) ? 1 : 0;
      end
   endtask

   task automatic drive(input logic rs, input logic e, input logic s,
                        input logic w, input logic [7:0] r);
      rst = rs; bus.en = e; bus.sync = s; bus.ratio_wr = w; bus.ratio_in = r;
      #1;
   endtask

   task automatic check_model();
      int exp_tick, exp_taps;
      if (!m_valid) return;
      exp_tick = (bus.en && !bus.sync && (m_cnt == m_n - 1)) ? 1 : 0;
`ifdef FD_TAPS_EN
      exp_taps = m_ticks % (1 << NTAPS);
`else
      exp_taps = 0;
`endif
      chk("model_cnt",     32'(bus.cnt),       32'(m_cnt));
      chk("model_ratio",   32'(bus.ratio_cur), 32'(m_n));
      chk("model_pending", 32'(bus.pending),   32'(m_pend));
      chk("model_tick",    32'(bus.tick),      32'(exp_tick));
      chk("model_clk_out", 32'(bus.clk_out),   32'(m_clk));
      chk("model_taps",    32'(bus.taps),      32'(exp_taps));
   endtask

   task automatic advance();
      logic rs, e, s, w;
      logic [7:0] r;
      rs = rst; e = bus.en; s = bus.sync; w = bus.ratio_wr; r = bus.ratio_in;
      @(posedge clk);
      model_step(rs, e, s, w, r);
      @(negedge clk);
   endtask

   task automatic step(input logic rs, input logic e, input logic s,
                       input logic w, input logic [7:0] r);
      drive(rs, e, s, w, r);
      check_model();
      advance();
   endtask

   vec_t tbl[32];

   initial begin
      bit found;
      int gap;

      // rst, en, sync, wr, rin, chk, cnt, ratio, pend, tick, clk_out
      tbl[0]  = mk(1,0,0,0,0, 0, 0,0,0,0,0);
      tbl[1]  = mk(0,1,0,0,0, 1, 0,2,0,0,0);
      tbl[2]  = mk(0,1,0,0,0, 1, 1,2,0,1,1);
      tbl[3]  = mk(0,1,0,1,5, 1, 0,2,0,0,0);
      tbl[4]  = mk(0,1,0,0,0, 1, 1,2,1,1,1);
      tbl[5]  = mk(0,1,0,0,0, 1, 0,5,0,0,0);
      tbl[6]  = mk(0,1,0,0,0, 1, 1,5,0,0,0);
      tbl[7]  = mk(0,1,0,0,0, 1, 2,5,0,0,1);
      tbl[8]  = mk(0,1,0,0,0, 1, 3,5,0,0,1);
      tbl[9]  = mk(0,1,0,0,0, 1, 4,5,0,1,1);
      tbl[10] = mk(0,0,0,1,0, 1, 0,5,0,0,0);
      tbl[11] = mk(0,0,0,0,0, 1, 0,1,0,0,0);
      tbl[12] = mk(0,1,0,0,0, 1, 0,1,0,1,0);
      tbl[13] = mk(0,1,0,0,0, 1, 0,1,0,1,1);
      tbl[14] = mk(0,1,0,0,0, 1, 0,1,0,1,1);
      tbl[15] = mk(0,0,0,1,6, 1, 0,1,0,0,1);
      tbl[16] = mk(0,1,0,0,0, 1, 0,6,0,0,0);
      tbl[17] = mk(0,1,0,0,0, 1, 1,6,0,0,0);
      tbl[18] = mk(0,1,0,0,0, 1, 2,6,0,0,0);
      tbl[19] = mk(0,1,1,0,0, 1, 3,6,0,0,1);
      tbl[20] = mk(0,1,0,0,0, 1, 0,6,0,0,0);
      tbl[21] = mk(0,1,0,0,0, 1, 1,6,0,0,0);
      tbl[22] = mk(0,1,0,0,0, 1, 2,6,0,0,0);
      tbl[23] = mk(0,1,0,0,0, 1, 3,6,0,0,1);
      tbl[24] = mk(0,1,0,0,0, 1, 4,6,0,0,1);
      tbl[25] = mk(0,1,0,0,0, 1, 5,6,0,1,1);
      tbl[26] = mk(0,0,0,1,4, 1, 0,6,0,0,0);
      tbl[27] = mk(0,1,0,0,0, 1, 0,4,0,0,0);
      tbl[28] = mk(0,1,0,1,9, 1, 1,4,0,0,0);
      tbl[29] = mk(1,1,0,0,0, 1, 2,4,1,0,1);
      tbl[30] = mk(0,1,0,0,0, 1, 0,2,0,0,0);
      tbl[31] = mk(0,1,0,0,0, 1, 1,2,0,1,1);

      rst = 1'b1; bus.en = 1'b0; bus.sync = 1'b0; bus.ratio_wr = 1'b0; bus.ratio_in = '0;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 32; i++) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].sync, tbl[i].wr, tbl[i].rin);
         if (tbl[i].chk) begin
            chk($sformatf("vec%0d_cnt", i),     32'(bus.cnt),       32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ratio", i),   32'(bus.ratio_cur), 32'(tbl[i].ratio));
            chk($sformatf("vec%0d_pending", i), 32'(bus.pending),   32'(tbl[i].pend));
            chk($sformatf("vec%0d_tick", i),    32'(bus.tick),      32'(tbl[i].tick));
            chk($sformatf("vec%0d_clk_out", i), 32'(bus.clk_out),   32'(tbl[i].clk_out));
         end
         check_model();
         advance();
      end

      // N=7 running, writes of 4 then 9 before the boundary: only 9 applies
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd7);
      chk("seq_n7_loaded", 32'(bus.ratio_cur), 32'd7);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
      chk("seq_pending_set", 32'(bus.pending), 32'd1);
      chk("seq_still_n7", 32'(bus.ratio_cur), 32'd7);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
         check_model();
         if (bus.tick === 1'b1) found = 1'b1;
         advance();
      end
      chk("seq_boundary_found", 32'(found), 32'd1);
      chk("seq_ratio_9", 32'(bus.ratio_cur), 32'd9);
      chk("seq_pending_clear", 32'(bus.pending), 32'd0);
      found = 1'b0;
      gap = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
         check_model();
         if (bus.tick === 1'b1) begin
            found = 1'b1;
            gap = i;
         end
         advance();
      end
      chk("seq_gap_9", 32'(gap), 32'd9);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         logic rs, e, s, w;
         logic [7:0] r;
         rs = ($urandom_range(0, 299) == 0);
         e  = ($urandom_range(0, 99) < 85);
         s  = ($urandom_range(0, 39) == 0);
         w  = ($urandom_range(0, 14) == 0);
         r  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 12));
         step(rs, e, s, w, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
